anton_neopixel_stream_sequencer: RTL



---
 rtl/anton_neopixel_stream_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/anton_neopixel_stream_sequencer.sv
// anton_neopixel_stream_sequencer: NeoPixel stream timing sequencer (sub-bit, bit, pixel and reset-gap counters).
// Ports:
//   clk6_4mhz, syncReset          - stream clock, synchronous active-high reset
//   regCtrlInit/Run/Loop          - control: init hold, run enable, continuous (1) or one-shot (0)
//   regCtrlLimit, regMax          - clamp the last pixel to regMax (saturated to BUFFER_END)
//   regCtrl32bit, regCtrlRgbw     - 4-byte pixel stepping, 32 bits per pixel instead of 24
//   regResetDelay                 - reset-gap ticks, 0 selects RESET_DELAY
//   initSlow / initSlowDone       - clear all counters / one-cycle acknowledge
//   bitPatternIndex, pixelBitIndex, pixelIndex, pixelIndexMax, state - position and status
//   streamOutput, streamReset     - active TRANSMIT / RESET-gap cycles
//   streamBitOf, streamPixelOf, streamSyncOf, frameDone - end of pixel, end of frame data, end of gap
// Optional: define ANTON_STREAM_FRAME_COUNTER_EN to add the 16-bit frameCount output.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 320
`endif
module anton_neopixel_stream_sequencer #(
    parameter int BUFFER_END    = `BUFFER_END_DEFAULT,
    parameter int RESET_DELAY   = `RESET_DELAY_DEFAULT,
    parameter int PATTERN_STEPS = 8,
    localparam int BUFFER_BITS  = `CLOG2(BUFFER_END + 1),
    localparam int PATTERN_BITS = `CLOG2(PATTERN_STEPS)
) (
    input  logic                    clk6_4mhz,
    input  logic                    syncReset,
    input  logic                    regCtrlInit,
    input  logic                    regCtrlRun,
    input  logic                    regCtrlLoop,
    input  logic                    regCtrlLimit,
    input  logic                    regCtrl32bit,
    input  logic                    regCtrlRgbw,
    input  logic [12:0]             regMax,
    input  logic [11:0]             regResetDelay,
    input  logic                    initSlow,
    output logic                    initSlowDone,
    output logic [PATTERN_BITS-1:0] bitPatternIndex,
    output logic [4:0]              pixelBitIndex,
    output logic [BUFFER_BITS-1:0]  pixelIndex,
    output logic [BUFFER_BITS-1:0]  pixelIndexMax,
    output logic [1:0]              state,
    output logic                    streamOutput,
    output logic                    streamReset,
    output logic                    streamBitOf,
    output logic                    streamPixelOf,
    output logic                    streamSyncOf,
`ifdef ANTON_STREAM_FRAME_COUNTER_EN
    output logic [15:0]             frameCount,
`endif
    output logic                    frameDone
);
    typedef enum logic [1:0] {IDLE = 2'd0, TRANSMIT = 2'd1, RESET = 2'd2, DONE = 2'd3} state_t;

    localparam logic [BUFFER_BITS-1:0]  BUF_END     = BUFFER_BITS'(BUFFER_END);
    localparam logic [12:0]             BUF_END_W   = 13'(BUFFER_END);
    localparam logic [BUFFER_BITS-1:0]  WORD_MASK   = BUFFER_BITS'(3);
    localparam logic [PATTERN_BITS-1:0] PAT_LAST    = PATTERN_BITS'(PATTERN_STEPS - 1);
    localparam logic [11:0]             GAP_DEFAULT = 12'(RESET_DELAY);

    state_t                  state_q, state_d;
    logic [PATTERN_BITS-1:0] pat_q, pat_d;
    logic [4:0]              bit_q, bit_d;
    logic [BUFFER_BITS-1:0]  pix_q, pix_d;
    logic [11:0]             gap_q, gap_d;
    logic                    init_prev_q, init_done_q;
    logic                    active, pattern_of, pixel_last;
    logic [4:0]              bit_last;
    logic [11:0]             gap_target;

    always_comb begin
        active        = regCtrlRun && !regCtrlInit;
        streamOutput  = active && state_q == TRANSMIT;
        streamReset   = active && state_q == RESET;
        pattern_of    = streamOutput && pat_q == PAT_LAST;
        bit_last      = regCtrlRgbw ? 5'd31 : 5'd23;
        // >= keeps a 32->24 bit switch mid-pixel from running past the boundary
        streamBitOf   = pattern_of && bit_q >= bit_last;
        pixelIndexMax = (regCtrlLimit && regMax <= BUF_END_W) ? regMax[BUFFER_BITS-1:0] : BUF_END;
        // 32-bit mode compares whole 4-byte words
        pixel_last    = regCtrl32bit ? ((pix_q | WORD_MASK) >= (pixelIndexMax & ~WORD_MASK))
                                     : (pix_q >= pixelIndexMax);
        streamPixelOf = streamBitOf && pixel_last;
        gap_target    = regResetDelay != 12'd0 ? regResetDelay : GAP_DEFAULT;
        streamSyncOf  = streamReset && gap_q >= gap_target;
        frameDone     = streamSyncOf;
    end

    always_comb begin
        pat_d   = streamOutput ? pat_q + PATTERN_BITS'(1) : pat_q;
        bit_d   = pattern_of ? (streamBitOf ? 5'd0 : bit_q + 5'd1) : bit_q;
        pix_d   = streamBitOf ? (pixel_last ? '0 : pix_q + (regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1))) : pix_q;
        gap_d   = streamReset ? (streamSyncOf ? 12'd0 : gap_q + 12'd1) : gap_q;
        state_d = !active ? IDLE :
                  state_q == IDLE ? TRANSMIT :
                  (streamPixelOf && !initSlow) ? RESET :
                  streamSyncOf ? (regCtrlLoop ? TRANSMIT : DONE) : state_q;
        if (initSlow) begin
            pat_d = '0;
            bit_d = '0;
            pix_d = '0;
            gap_d = '0;
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (syncReset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            bit_q       <= '0;
            pix_q       <= '0;
            gap_q       <= '0;
            init_prev_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            bit_q       <= bit_d;
            pix_q       <= pix_d;
            gap_q       <= gap_d;
            init_prev_q <= initSlow;
            init_done_q <= initSlow && !init_prev_q;
        end
    end

`ifdef ANTON_STREAM_FRAME_COUNTER_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk6_4mhz) begin
        if (syncReset || initSlow) frame_cnt_q <= '0;
        else if (frameDone) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frameCount = frame_cnt_q;
`endif

    assign state           = state_q;
    assign bitPatternIndex = pat_q;
    assign pixelBitIndex   = bit_q;
    assign pixelIndex      = pix_q;
    assign initSlowDone    = init_done_q;
endmodule
